// File: rtl/seq_mult_pkg.sv
// Shared helpers and state encoding for the iterative single-DSP signed multiplier.
// SEQ_MULT_MAC_EN widens the result path by ACC_EXT_W bits for multiply-accumulate.
package seq_mult_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((32'sd1 <<< result) < value) begin
      result = result + 32'sd1;
    end
    return (result < 32'sd1) ? 32'sd1 : result;
  endfunction

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 32'sd1) / den;
  endfunction

  // The top slice of a w-bit operand may use SLICE_W+1 bits because it is signed.
  function automatic int num_slices(input int width, input int slice_w);
    return ceil_div(width - 32'sd1, slice_w);
  endfunction

`ifdef SEQ_MULT_MAC_EN
  localparam int ACC_EXT_W = 4;
`else
  localparam int ACC_EXT_W = 0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/dsp_mul_pipe.sv
// Signed DW x DW multiplier with LAT output registers; carries a valid and a shift tag
// alongside the product so the consumer never depends on data-dependent timing.
module dsp_mul_pipe #(
  parameter int DW    = 18,
  parameter int LAT   = 2,
  parameter int TAG_W = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  input  logic [TAG_W-1:0]        i_tag,
  input  logic signed [DW-1:0]    i_a,
  input  logic signed [DW-1:0]    i_b,
  output logic                    o_valid,
  output logic [TAG_W-1:0]        o_tag,
  output logic signed [2*DW-1:0]  o_p
);

  logic signed [2*DW-1:0] p_r   [LAT];
  logic [TAG_W-1:0]       tag_r [LAT];
  logic [LAT-1:0]         valid_r;

  // Valid chain, cleared by reset so an aborted operation leaves nothing in flight
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_r <= '0;
    end else begin
      valid_r[0] <= i_valid;
      for (int k = 1; k < LAT; k++) begin
        valid_r[k] <= valid_r[k-1];
      end
    end
  end

  // Product and tag pipeline without reset so it maps onto DSP pipeline registers
  always_ff @(posedge i_clk) begin
    p_r[0]   <= i_a * i_b;
    tag_r[0] <= i_tag;
    for (int k = 1; k < LAT; k++) begin
      p_r[k]   <= p_r[k-1];
      tag_r[k] <= tag_r[k-1];
    end
  end

  assign o_valid = valid_r[LAT-1];
  assign o_tag   = tag_r[LAT-1];
  assign o_p     = p_r[LAT-1];

endmodule

// File: rtl/seq_mult_1dsp_param.sv
// Iterative signed multiplier reusing one DSP over NA*NB slice pairs, valid/ready on both sides.
// Optional multiply-accumulate (i_acc, wider result) is enabled by defining SEQ_MULT_MAC_EN.
module seq_mult_1dsp_param
  import seq_mult_pkg::*;
#(
  parameter int A_W     = 52,
  parameter int B_W     = 52,
  parameter int SLICE_W = 17,
  parameter int DSP_LAT = 2
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_valid,
  output logic                                 o_ready,
  input  logic signed [A_W-1:0]                i_a,
  input  logic signed [B_W-1:0]                i_b,
`ifdef SEQ_MULT_MAC_EN
  input  logic                                 i_acc,
`endif
  output logic                                 o_valid,
  input  logic                                 i_ready,
  output logic signed [A_W+B_W+ACC_EXT_W-1:0]  o_p
);

  localparam int NA    = num_slices(A_W, SLICE_W);
  localparam int NB    = num_slices(B_W, SLICE_W);
  localparam int N     = NA * NB;
  localparam int P_W   = A_W + B_W;
  localparam int ACC_W = P_W + ACC_EXT_W;
  localparam int DW    = SLICE_W + 1;
  localparam int I_W   = clog2(NA);
  localparam int J_W   = clog2(NB);
  localparam int C_W   = clog2(N);
  localparam int TAG_W = clog2(NA + NB - 1);
  localparam int EA_W  = NA * SLICE_W + 1;
  localparam int EB_W  = NB * SLICE_W + 1;

  state_e                  state_r, state_s;
  logic                    accept_s, mac_s, mac_r;
  logic signed [A_W-1:0]   a_r;
  logic signed [B_W-1:0]   b_r;
  logic [I_W-1:0]          i_cnt_r;
  logic [J_W-1:0]          j_cnt_r;
  logic                    last_pair_s;
  logic signed [EA_W-1:0]  a_ext_s;
  logic signed [EB_W-1:0]  b_ext_s;
  logic [DW-1:0]           a_win_s, b_win_s;
  logic signed [DW-1:0]    sa_s, sb_s, sa_r, sb_r;
  logic                    s_valid_r;
  logic [TAG_W-1:0]        s_tag_r;
  logic                    pp_valid_s;
  logic [TAG_W-1:0]        pp_tag_s;
  logic signed [2*DW-1:0]  pp_s;
  logic signed [ACC_W-1:0] pp_ext_s, pp_sh_s, base_s, acc_r, o_p_r;
  logic [C_W-1:0]          acc_cnt_r;
  logic                    acc_done_r;

  assign accept_s    = (state_r == ST_IDLE) && i_valid;
  assign last_pair_s = (i_cnt_r == I_W'(NA - 1)) && (j_cnt_r == J_W'(NB - 1));

`ifdef SEQ_MULT_MAC_EN
  assign mac_s = i_acc;
`else
  assign mac_s = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  if (i_valid)     state_s = ST_ISSUE; else state_s = ST_IDLE;
      ST_ISSUE: if (last_pair_s) state_s = ST_DRAIN; else state_s = ST_ISSUE;
      ST_DRAIN: if (acc_done_r)  state_s = ST_DONE;  else state_s = ST_DRAIN;
      ST_DONE:  if (i_ready)     state_s = ST_IDLE;  else state_s = ST_DONE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // FSM output decode from the state register
  always_comb begin
    o_ready = (state_r == ST_IDLE);
    o_valid = (state_r == ST_DONE);
  end

  // Operand capture on the accept edge
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_r   <= '0;
      b_r   <= '0;
      mac_r <= 1'b0;
    end else if (accept_s) begin
      a_r   <= i_a;
      b_r   <= i_b;
      mac_r <= mac_s;
    end
  end

  // Slice counters: i (A) outer, j (B) inner, one pair per ISSUE cycle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      i_cnt_r <= '0;
      j_cnt_r <= '0;
    end else if (state_r == ST_ISSUE) begin
      if (j_cnt_r == J_W'(NB - 1)) begin
        j_cnt_r <= '0;
        i_cnt_r <= (i_cnt_r == I_W'(NA - 1)) ? '0 : i_cnt_r + I_W'(1);
      end else begin
        j_cnt_r <= j_cnt_r + J_W'(1);
      end
    end
  end

  // Sign-extending first lets the top slice pick up its sign bit; lower slices force it to zero
  assign a_ext_s = EA_W'(a_r);
  assign b_ext_s = EB_W'(b_r);
  assign a_win_s = a_ext_s[SLICE_W*int'(i_cnt_r) +: DW];
  assign b_win_s = b_ext_s[SLICE_W*int'(j_cnt_r) +: DW];
  assign sa_s    = {(i_cnt_r == I_W'(NA - 1)) ? a_win_s[SLICE_W] : 1'b0, a_win_s[SLICE_W-1:0]};
  assign sb_s    = {(j_cnt_r == J_W'(NB - 1)) ? b_win_s[SLICE_W] : 1'b0, b_win_s[SLICE_W-1:0]};

  // Slice pair register feeding the DSP operand ports
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s_valid_r <= 1'b0;
      s_tag_r   <= '0;
      sa_r      <= '0;
      sb_r      <= '0;
    end else begin
      s_valid_r <= (state_r == ST_ISSUE);
      s_tag_r   <= TAG_W'(i_cnt_r) + TAG_W'(j_cnt_r);
      sa_r      <= sa_s;
      sb_r      <= sb_s;
    end
  end

  dsp_mul_pipe #(
    .DW    (DW),
    .LAT   (DSP_LAT),
    .TAG_W (TAG_W)
  ) u_dsp (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (s_valid_r),
    .i_tag   (s_tag_r),
    .i_a     (sa_r),
    .i_b     (sb_r),
    .o_valid (pp_valid_s),
    .o_tag   (pp_tag_s),
    .o_p     (pp_s)
  );

  assign pp_ext_s = ACC_W'(pp_s);
  assign pp_sh_s  = pp_ext_s <<< (SLICE_W * int'(pp_tag_s));
  assign base_s   = mac_r ? o_p_r : '0;

  // Shift-accumulate: first partial product loads, the rest add; the last one raises acc_done_r
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_r      <= '0;
      acc_cnt_r  <= '0;
      acc_done_r <= 1'b0;
    end else if (pp_valid_s) begin
      acc_r      <= (acc_cnt_r == '0) ? base_s + pp_sh_s : acc_r + pp_sh_s;
      acc_done_r <= (acc_cnt_r == C_W'(N - 1));
      acc_cnt_r  <= (acc_cnt_r == C_W'(N - 1)) ? '0 : acc_cnt_r + C_W'(1);
    end else begin
      acc_done_r <= 1'b0;
    end
  end

  // Result register, loaded as the FSM enters DONE and held under backpressure
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_p_r <= '0;
    end else if ((state_r == ST_DRAIN) && acc_done_r) begin
      o_p_r <= acc_r;
    end
  end

  assign o_p = o_p_r;

endmodule

// File: tb/tb_seq_mult_1dsp_param.sv
// Directed bench for seq_mult_1dsp_param: default 52x52 instance plus a 30x20 / DSP_LAT=3 instance.
// With SEQ_MULT_MAC_EN defined the multiply-accumulate sequence is exercised as well.
module tb_seq_mult_1dsp_param;

`ifdef SEQ_MULT_MAC_EN
  localparam int EXT_W = 4;
`else
  localparam int EXT_W = 0;
`endif
  localparam int PW1 = 104 + EXT_W;
  localparam int PW2 = 50 + EXT_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic valid1, oready1, ovalid1, ready1;
  logic signed [51:0] a1, b1;
  logic signed [PW1-1:0] p1;
  logic valid2, oready2, ovalid2, ready2;
  logic signed [29:0] a2;
  logic signed [19:0] b2;
  logic signed [PW2-1:0] p2;
`ifdef SEQ_MULT_MAC_EN
  logic acc1;
  logic acc2;
`endif

  int checks = 0;
  int errors = 0;

  seq_mult_1dsp_param dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid1), .o_ready(oready1),
    .i_a(a1), .i_b(b1),
`ifdef SEQ_MULT_MAC_EN
    .i_acc(acc1),
`endif
    .o_valid(ovalid1), .i_ready(ready1), .o_p(p1)
  );

  seq_mult_1dsp_param #(.A_W(30), .B_W(20), .SLICE_W(17), .DSP_LAT(3)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid2), .o_ready(oready2),
    .i_a(a2), .i_b(b2),
`ifdef SEQ_MULT_MAC_EN
    .i_acc(acc2),
`endif
    .o_valid(ovalid2), .i_ready(ready2), .o_p(p2)
  );

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction on dut1 with i_ready held high; exp is the exact 104-bit product
  task automatic run1(input string tag, input logic signed [51:0] a, input logic signed [51:0] b,
                      input logic signed [103:0] exp);
    int   lat;
    logic rdy_seen;
    @(negedge clk);
    check_bit({tag, " ready before"}, oready1, 1'b1);
    a1 = a; b1 = b; valid1 = 1'b1; ready1 = 1'b1;
    @(negedge clk);
    valid1 = 1'b0; a1 = 52'($urandom); b1 = 52'($urandom);
    lat = 0; rdy_seen = 1'b0;
    while (!ovalid1 && lat < 40) begin
      rdy_seen = rdy_seen | oready1;
      @(negedge clk);
      lat++;
    end
    rdy_seen = rdy_seen | oready1;
    check_int({tag, " latency"}, lat, 13);
    check_bit({tag, " ready low while busy"}, rdy_seen, 1'b0);
    check_val({tag, " product"}, 128'(p1), 128'(PW1'(exp)));
    @(negedge clk);
    check_bit({tag, " valid after transfer"}, ovalid1, 1'b0);
    check_bit({tag, " ready after transfer"}, oready1, 1'b1);
  endtask

  // Transaction on dut2 checked against a wide signed multiply
  task automatic run2(input logic signed [29:0] a, input logic signed [19:0] b);
    logic signed [49:0] e;
    int lat;
    e = 50'(a) * 50'(b);
    @(negedge clk);
    check_bit("dut2 ready", oready2, 1'b1);
    a2 = a; b2 = b; valid2 = 1'b1; ready2 = 1'b1;
    @(negedge clk);
    valid2 = 1'b0;
    lat = 0;
    while (!ovalid2 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_int("dut2 latency", lat, 9);
    check_val("dut2 product", 128'(p2), 128'(PW2'(e)));
  endtask

  initial begin
    int   lat;
    logic hold_bad, seen;
    logic signed [103:0] exp_hold;
    rst = 1'b1;
    valid1 = 1'b0; ready1 = 1'b0; a1 = '0; b1 = '0;
    valid2 = 1'b0; ready2 = 1'b0; a2 = '0; b2 = '0;
`ifdef SEQ_MULT_MAC_EN
    acc1 = 1'b0; acc2 = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_bit("reset valid", ovalid1, 1'b0);
    check_val("reset product", 128'(p1), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    check_bit("ready after reset", oready1, 1'b1);
    check_bit("valid after reset", ovalid1, 1'b0);

    run1("3x-5", 52'sd3, -52'sd5, -104'sd15);
    run1("min x min", 52'sh8000000000000, 52'sh8000000000000, 104'sd1 <<< 102);
    run1("max x min", 52'sh7FFFFFFFFFFFF, 52'sh8000000000000, (104'sd1 <<< 51) - (104'sd1 <<< 102));
    run1("max x max", 52'sh7FFFFFFFFFFFF, 52'sh7FFFFFFFFFFFF,
         (104'sd1 <<< 102) - (104'sd1 <<< 52) + 104'sd1);
    run1("-1 x -1", -52'sd1, -52'sd1, 104'sd1);
    run1("slice edge", 52'sd131071, 52'sd131072, (104'sd1 <<< 34) - (104'sd1 <<< 17));
    run1("big mixed", 52'sd123456789, -52'sd987654321, -104'sd121932631112635269);
    run1("zero", 52'sd0, 52'sd12345, 104'sd0);

    // Backpressure: result must hold for 20 cycles and a new i_valid must be ignored
    exp_hold = 104'sd1000 * -104'sd77;
    @(negedge clk);
    a1 = 52'sd1000; b1 = -52'sd77; valid1 = 1'b1; ready1 = 1'b0;
    @(negedge clk);
    valid1 = 1'b0;
    lat = 0;
    while (!ovalid1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_int("backpressure latency", lat, 13);
    check_val("backpressure product", 128'(p1), 128'(PW1'(exp_hold)));
    hold_bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      valid1 = (k == 5);
      a1 = 52'sd9; b1 = 52'sd9;
      @(negedge clk);
      if (ovalid1 !== 1'b1 || p1 !== PW1'(exp_hold) || oready1 !== 1'b0) hold_bad = 1'b1;
    end
    valid1 = 1'b0;
    check_bit("backpressure hold", hold_bad, 1'b0);
    ready1 = 1'b1;
    @(negedge clk);
    check_bit("backpressure release valid", ovalid1, 1'b0);
    check_bit("backpressure release ready", oready1, 1'b1);
    run1("after backpressure", -52'sd4, 52'sd25, -104'sd100);

    // Reset in the middle of an operation
    @(negedge clk);
    a1 = 52'sd11; b1 = 52'sd13; valid1 = 1'b1; ready1 = 1'b1;
    @(negedge clk);
    valid1 = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check_bit("midop reset ready", oready1, 1'b1);
    check_bit("midop reset valid", ovalid1, 1'b0);
    check_val("midop reset product", 128'(p1), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      seen = seen | ovalid1;
    end
    check_bit("no result after reset", seen, 1'b0);
    run1("after reset", 52'sd11, 52'sd13, 104'sd143);

`ifdef SEQ_MULT_MAC_EN
    acc1 = 1'b0;
    run1("mac first", 52'sd7, 52'sd6, 104'sd42);
    acc1 = 1'b1;
    run1("mac accumulate", 52'sd2, -52'sd3, 104'sd36);
    acc1 = 1'b0;
`endif

    // Narrow configuration: boundaries then random pairs
    run2(30'sh20000000, 20'sh80000);
    run2(30'sh1FFFFFFF, 20'sh80000);
    run2(-30'sd1, 20'sh7FFFF);
    for (int k = 0; k < 150; k++) begin
      run2(30'($urandom), 20'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
